// File: rtl/mcp_data_path_hs.sv
// Multicycle MIPS datapath with a request/ready memory port, a global stall that
// freezes all architectural state while an access is outstanding, and a memory watchdog.
//
// Memory FSM:
//   state  | meaning
//   IDLE   | no access outstanding; a request with ready completes in this cycle
//   WAIT   | request issued, waiting for mem_ready_i; watchdog counting
//   ERR    | watchdog expired; core frozen until reset
//
// b_alu_input_i2: 0 = B, 1 = 4, 2 = sign-extended imm, 3 = sign-extended imm << 2
// alu_alt_ctrl_i2: 0 = add, 1 = sub, 2 = decode IR funct (add/sub/and/or/slt), 3 = or
module mcp_data_path_hs #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        pc_we_i,
  input  logic        instr_we_i,
  input  logic        reg_dst_rtrd_i,
  input  logic        mem_to_reg_i,
  input  logic        enable_wrf_i,
  input  logic        a_alu_input_i,
  input  logic [1:0]  pc_branch_i2,
  input  logic [1:0]  b_alu_input_i2,
  input  logic [1:0]  alu_alt_ctrl_i2,
  input  logic        instr_or_data_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic        mem_ready_i,
  input  logic [31:0] read_data_i32,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] addr_o32,
  output logic [31:0] write_data_o32,
  output logic        stall_o,
  output logic        mem_err_o,
  output logic        zero_o,
  output logic [31:0] instr_o32,
  output logic [31:0] pc_o32
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  localparam int CNT_W_RAW = $clog2(MEM_TIMEOUT + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(MEM_TIMEOUT);
  localparam bit WDG_EN = (MEM_TIMEOUT != 0);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_req;
  logic             w_in_idle;
  logic             w_in_wait;
  logic             w_in_err;
  logic             w_upd;

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_mdr;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_alu_out;
  logic [31:0] r_rf [32];

  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;
  logic [31:0] w_sext;
  logic [31:0] w_src_a;
  logic [31:0] w_src_b;
  logic [31:0] w_alu_res;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_wb_data;
  logic [4:0]  w_wb_addr;
  logic [2:0]  w_alu_op;

  // Memory handshake and stall
  assign w_req     = mem_rd_i | mem_wr_i;
  assign w_in_idle = (r_state == S_IDLE);
  assign w_in_wait = (r_state == S_WAIT);
  assign w_in_err  = (r_state == S_ERR);

  assign mem_req_o = (w_in_idle & w_req) | w_in_wait;
  assign mem_we_o  = mem_req_o & mem_wr_i;
  assign stall_o   = (mem_req_o & ~mem_ready_i) | w_in_err;
  assign mem_err_o = w_in_err;
  assign w_upd     = ~stall_o;

  assign w_cnt_inc = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_req & ~mem_ready_i) w_state_nxt = S_WAIT;
      S_WAIT: begin
        // a ready arriving in the timeout cycle still completes the access
        if (mem_ready_i)                         w_state_nxt = S_IDLE;
        else if (WDG_EN && (w_cnt_inc == CNT_TO)) w_state_nxt = S_ERR;
      end
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_in_wait) begin
        if (!mem_ready_i) r_wait_cnt <= w_cnt_inc;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  // Datapath
  assign w_rs_data = (r_ir[25:21] == 5'd0) ? 32'd0 : r_rf[r_ir[25:21]];
  assign w_rt_data = (r_ir[20:16] == 5'd0) ? 32'd0 : r_rf[r_ir[20:16]];
  assign w_sext    = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_src_a   = a_alu_input_i ? r_a : r_pc;
  assign w_wb_addr = reg_dst_rtrd_i ? r_ir[15:11] : r_ir[20:16];
  assign w_wb_data = mem_to_reg_i ? r_mdr : r_alu_out;

  always_comb begin
    w_src_b = r_b;
    case (b_alu_input_i2)
      2'd0:    w_src_b = r_b;
      2'd1:    w_src_b = 32'd4;
      2'd2:    w_src_b = w_sext;
      default: w_src_b = {w_sext[29:0], 2'b00};
    endcase
  end

  always_comb begin
    w_alu_op = ALU_ADD;
    case (alu_alt_ctrl_i2)
      2'd0: w_alu_op = ALU_ADD;
      2'd1: w_alu_op = ALU_SUB;
      2'd2: begin
        case (r_ir[5:0])
          6'h22:   w_alu_op = ALU_SUB;
          6'h24:   w_alu_op = ALU_AND;
          6'h25:   w_alu_op = ALU_OR;
          6'h2a:   w_alu_op = ALU_SLT;
          default: w_alu_op = ALU_ADD;
        endcase
      end
      default: w_alu_op = ALU_OR;
    endcase
  end

  always_comb begin
    w_alu_res = w_src_a + w_src_b;
    case (w_alu_op)
      ALU_SUB: w_alu_res = w_src_a - w_src_b;
      ALU_AND: w_alu_res = w_src_a & w_src_b;
      ALU_OR:  w_alu_res = w_src_a | w_src_b;
      ALU_SLT: w_alu_res = {31'd0, ($signed(w_src_a) < $signed(w_src_b))};
      default: w_alu_res = w_src_a + w_src_b;
    endcase
  end

  always_comb begin
    w_pc_nxt = r_pc;
    case (pc_branch_i2)
      2'd0:    w_pc_nxt = w_alu_res;
      2'd1:    w_pc_nxt = r_alu_out;
      2'd2:    w_pc_nxt = {r_pc[31:28], r_ir[25:0], 2'b00};
      default: w_pc_nxt = r_pc;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_pc      <= RESET_PC;
      r_ir      <= 32'd0;
      r_mdr     <= 32'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_alu_out <= 32'd0;
    end else if (w_upd) begin
      if (pc_we_i) r_pc <= w_pc_nxt;
      if (instr_we_i & mem_ready_i & mem_req_o) r_ir <= read_data_i32;
      if (mem_ready_i & mem_req_o & ~mem_we_o) r_mdr <= read_data_i32;
      r_a       <= w_rs_data;
      r_b       <= w_rt_data;
      r_alu_out <= w_alu_res;
    end
  end

  // Register file contents survive reset
  always_ff @(posedge clk_i) begin
    if (w_upd & enable_wrf_i) r_rf[w_wb_addr] <= w_wb_data;
  end

  assign addr_o32       = instr_or_data_i ? r_alu_out : r_pc;
  assign write_data_o32 = r_b;
  assign zero_o         = (w_alu_res == 32'd0);
  assign instr_o32      = r_ir;
  assign pc_o32         = r_pc;

endmodule

// File: tb/tb_mcp_data_path_hs.sv
// Bench for mcp_data_path_hs: directed handshake scenarios plus randomized controller
// steps checked against a step-level model of the datapath.
module tb_mcp_data_path_hs;

  localparam logic [31:0] RST_PC = 32'h0000_4000;
  localparam int          MEM_TO = 4;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b1;
  logic        pc_we_i, instr_we_i, reg_dst_rtrd_i, mem_to_reg_i, enable_wrf_i, a_alu_input_i;
  logic [1:0]  pc_branch_i2, b_alu_input_i2, alu_alt_ctrl_i2;
  logic        instr_or_data_i, mem_rd_i, mem_wr_i, mem_ready_i;
  logic [31:0] read_data_i32;
  logic        mem_req_o, mem_we_o, stall_o, mem_err_o, zero_o;
  logic [31:0] addr_o32, write_data_o32, instr_o32, pc_o32;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
  logic [31:0] m_rf [32];

  logic [31:0] last_addr0, last_wdata0;
  logic        last_we0;
  int          last_nstall, last_nreq;

  mcp_data_path_hs #(.RESET_PC(RST_PC), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .pc_we_i(pc_we_i), .instr_we_i(instr_we_i), .reg_dst_rtrd_i(reg_dst_rtrd_i),
    .mem_to_reg_i(mem_to_reg_i), .enable_wrf_i(enable_wrf_i), .a_alu_input_i(a_alu_input_i),
    .pc_branch_i2(pc_branch_i2), .b_alu_input_i2(b_alu_input_i2), .alu_alt_ctrl_i2(alu_alt_ctrl_i2),
    .instr_or_data_i(instr_or_data_i), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
    .mem_ready_i(mem_ready_i), .read_data_i32(read_data_i32),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .addr_o32(addr_o32),
    .write_data_o32(write_data_o32), .stall_o(stall_o), .mem_err_o(mem_err_o),
    .zero_o(zero_o), .instr_o32(instr_o32), .pc_o32(pc_o32)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "time limit expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_ctl();
    pc_we_i = 0; instr_we_i = 0; reg_dst_rtrd_i = 0; mem_to_reg_i = 0; enable_wrf_i = 0;
    a_alu_input_i = 0; pc_branch_i2 = 0; b_alu_input_i2 = 0; alu_alt_ctrl_i2 = 0;
    instr_or_data_i = 0; mem_rd_i = 0; mem_wr_i = 0; mem_ready_i = 0; read_data_i32 = 0;
  endtask

  function automatic logic [31:0] rf_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : m_rf[a];
  endfunction

  // ALU result implied by the current controls and model registers
  function automatic logic [31:0] m_alu();
    logic [31:0] a, b, imm;
    a   = a_alu_input_i ? m_a : m_pc;
    imm = 32'($signed(m_ir[15:0]));
    case (b_alu_input_i2)
      2'd0:    b = m_b;
      2'd1:    b = 32'd4;
      2'd2:    b = imm;
      default: b = imm * 4;
    endcase
    case (alu_alt_ctrl_i2)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd3: return a | b;
      default: begin
        case (m_ir[5:0])
          6'h22:   return a - b;
          6'h24:   return a & b;
          6'h25:   return a | b;
          6'h2a:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: return a + b;
        endcase
      end
    endcase
  endfunction

  // One controller step = exactly one committing edge; all updates use pre-step values
  task automatic m_commit(input bit acc, input logic [31:0] res);
    logic [31:0] o_pc, o_ir, o_mdr, o_alu, rsv, rtv;
    logic [4:0]  dst;
    o_pc = m_pc; o_ir = m_ir; o_mdr = m_mdr; o_alu = m_aluout;
    rsv = rf_rd(o_ir[25:21]);
    rtv = rf_rd(o_ir[20:16]);
    dst = reg_dst_rtrd_i ? o_ir[15:11] : o_ir[20:16];
    if (pc_we_i) begin
      case (pc_branch_i2)
        2'd0:    m_pc = res;
        2'd1:    m_pc = o_alu;
        2'd2:    m_pc = {o_pc[31:28], o_ir[25:0], 2'b00};
        default: m_pc = o_pc;
      endcase
    end
    if (acc && instr_we_i) m_ir = read_data_i32;
    if (acc && !mem_wr_i) m_mdr = read_data_i32;
    if (enable_wrf_i) m_rf[dst] = mem_to_reg_i ? o_mdr : o_alu;
    m_a = rsv; m_b = rtv; m_aluout = res;
  endtask

  // Controls are already set; memory answers after lat extra cycles
  task automatic run_step(input int lat, input bit stray);
    logic [31:0] exp_res, exp_addr;
    bit acc;
    int ncyc;
    acc = mem_rd_i | mem_wr_i;
    ncyc = acc ? lat + 1 : 1;
    exp_res = m_alu();
    exp_addr = instr_or_data_i ? m_aluout : m_pc;
    last_nstall = 0;
    last_nreq = 0;
    for (int c = 0; c < ncyc; c++) begin
      mem_ready_i = acc ? (c == lat) : stray;
      @(negedge clk_i);
      if (c == 0) begin
        last_addr0 = addr_o32; last_wdata0 = write_data_o32; last_we0 = mem_we_o;
      end
      chk("addr", addr_o32, exp_addr);
      chk("wdata", write_data_o32, m_b);
      chk("req", 32'(mem_req_o), 32'(acc));
      chk("we", 32'(mem_we_o), 32'(acc & mem_wr_i));
      chk("stall", 32'(stall_o), 32'(acc && (c < lat)));
      chk("err", 32'(mem_err_o), 32'd0);
      chk("pc", pc_o32, m_pc);
      chk("instr", instr_o32, m_ir);
      chk("zero", 32'(zero_o), 32'(exp_res == 32'd0));
      if (stall_o) last_nstall++;
      if (mem_req_o) last_nreq++;
      @(posedge clk_i); #1;
    end
    if (acc) begin
      chk("n_stall", 32'(last_nstall), 32'(lat));
      chk("n_req", 32'(last_nreq), 32'(lat + 1));
    end
    m_commit(acc, exp_res);
    mem_ready_i = 0;
  endtask

  task automatic do_reset(input string tag);
    logic [31:0] res;
    clr_ctl();
    reset_ni = 0;
    #2;
    chk({tag, "_pc"}, pc_o32, RST_PC);
    chk({tag, "_instr"}, instr_o32, 32'd0);
    chk({tag, "_req"}, 32'(mem_req_o), 32'd0);
    chk({tag, "_we"}, 32'(mem_we_o), 32'd0);
    chk({tag, "_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_err"}, 32'(mem_err_o), 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1;
    m_pc = RST_PC; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0;
    res = m_alu();
    @(posedge clk_i); #1;
    m_commit(1'b0, res);
  endtask

  initial begin
    clr_ctl();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    #1;
    do_reset("rst0");

    // Give every register a known value: fetch word naming rd, then write MDR back
    for (int r = 1; r < 32; r++) begin
      clr_ctl();
      mem_rd_i = 1; instr_we_i = 1;
      read_data_i32 = {16'h0, 5'(r), 11'($urandom())};
      run_step($urandom_range(0, 2), 1'b0);
      clr_ctl();
      enable_wrf_i = 1; reg_dst_rtrd_i = 1; mem_to_reg_i = 1;
      run_step(0, 1'b0);
    end

    do_reset("rst1");

    // Zero-wait fetch
    clr_ctl();
    mem_rd_i = 1; instr_we_i = 1; pc_we_i = 1; b_alu_input_i2 = 2'd1;
    read_data_i32 = 32'h2008_0005;
    run_step(0, 1'b0);
    chk("zw_addr", last_addr0, RST_PC);
    chk("zw_nstall", 32'(last_nstall), 32'd0);
    chk("zw_instr", instr_o32, 32'h2008_0005);
    chk("zw_pc", pc_o32, RST_PC + 32'd4);

    // 3-cycle fetch of lw $9, 0x10($0)
    clr_ctl();
    mem_rd_i = 1; instr_we_i = 1; pc_we_i = 1; b_alu_input_i2 = 2'd1;
    read_data_i32 = 32'h8C09_0010;
    run_step(3, 1'b0);
    chk("f3_nstall", 32'(last_nstall), 32'd3);
    chk("f3_nreq", 32'(last_nreq), 32'd4);
    chk("f3_instr", instr_o32, 32'h8C09_0010);
    chk("f3_pc", pc_o32, RST_PC + 32'd8);

    // Load DEADBEEF into $9, then form ALUOut=0x10 with B=$9
    clr_ctl();
    mem_rd_i = 1; instr_or_data_i = 1; read_data_i32 = 32'hDEAD_BEEF;
    run_step(1, 1'b0);
    clr_ctl();
    enable_wrf_i = 1; mem_to_reg_i = 1; a_alu_input_i = 1; b_alu_input_i2 = 2'd2;
    run_step(0, 1'b0);
    clr_ctl();
    a_alu_input_i = 1; b_alu_input_i2 = 2'd2;
    run_step(0, 1'b0);

    // Store with two wait cycles
    clr_ctl();
    mem_wr_i = 1; instr_or_data_i = 1; read_data_i32 = 32'h5555_AAAA;
    run_step(2, 1'b0);
    chk("st_addr", last_addr0, 32'h0000_0010);
    chk("st_wdata", last_wdata0, 32'hDEAD_BEEF);
    chk("st_we", 32'(last_we0), 32'd1);
    chk("st_nreq", 32'(last_nreq), 32'd3);

    // Simultaneous read+write: write wins, MDR keeps DEADBEEF
    clr_ctl();
    mem_rd_i = 1; mem_wr_i = 1; instr_or_data_i = 1; read_data_i32 = 32'h1234_5678;
    run_step(0, 1'b0);
    chk("rw_we", 32'(last_we0), 32'd1);
    clr_ctl();
    enable_wrf_i = 1; mem_to_reg_i = 1;
    run_step(0, 1'b0);
    clr_ctl();
    run_step(0, 1'b0);
    chk("rw_mdr", write_data_o32, 32'hDEAD_BEEF);

    // Randomized controller steps, latencies up to the timeout boundary
    for (int s = 0; s < 300; s++) begin
      int k;
      clr_ctl();
      k = $urandom_range(0, 5);
      mem_rd_i        = (k == 3 || k == 5);
      mem_wr_i        = (k == 4 || k == 5);
      pc_we_i         = 1'($urandom_range(0, 1));
      instr_we_i      = 1'($urandom_range(0, 1));
      reg_dst_rtrd_i  = 1'($urandom_range(0, 1));
      mem_to_reg_i    = 1'($urandom_range(0, 1));
      enable_wrf_i    = 1'($urandom_range(0, 1));
      a_alu_input_i   = 1'($urandom_range(0, 1));
      instr_or_data_i = 1'($urandom_range(0, 1));
      pc_branch_i2    = 2'($urandom_range(0, 3));
      b_alu_input_i2  = 2'($urandom_range(0, 3));
      alu_alt_ctrl_i2 = 2'($urandom_range(0, 3));
      read_data_i32   = $urandom();
      run_step($urandom_range(0, MEM_TO), 1'($urandom_range(0, 1)));
    end

    // Watchdog: error on the edge after MEM_TO wait cycles, then terminal
    clr_ctl();
    mem_rd_i = 1; instr_we_i = 1; pc_we_i = 1; b_alu_input_i2 = 2'd1;
    for (int c = 0; c < MEM_TO + 4; c++) begin
      bit in_err;
      in_err = (c > MEM_TO);
      @(negedge clk_i);
      chk("wd_req", 32'(mem_req_o), 32'(!in_err));
      chk("wd_stall", 32'(stall_o), 32'd1);
      chk("wd_err", 32'(mem_err_o), 32'(in_err));
      chk("wd_pc", pc_o32, m_pc);
      chk("wd_instr", instr_o32, m_ir);
      @(posedge clk_i); #1;
      if (c >= MEM_TO) mem_ready_i = 1;
    end
    do_reset("wd_rst");

    // Async reset in the middle of a wait
    clr_ctl();
    mem_rd_i = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("mw_stall", 32'(stall_o), 32'd1);
      @(posedge clk_i); #1;
    end
    @(negedge clk_i); #2;
    do_reset("mw_rst");

    clr_ctl();
    mem_rd_i = 1; instr_we_i = 1; pc_we_i = 1; b_alu_input_i2 = 2'd1;
    read_data_i32 = 32'h0123_4567;
    run_step(1, 1'b0);
    chk("post_instr", instr_o32, 32'h0123_4567);
    chk("post_pc", pc_o32, RST_PC + 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
